// File: rtl/noc_flit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : noc_flit_pkg                                                  |
// | Purpose  : Shared flit layout for the NoC router datapath. A flit is     |
// |            {valid, port_tag, dst, src, pktid, data}, MSB to LSB. The     |
// |            offset helpers give the LSB position of each field so every   |
// |            consumer slices flits the same way.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package noc_flit_pkg;

    // Port tag carried by flits entering the network from the local PE.
    localparam logic [2:0] c_LOCAL_TAG = 3'd4;

    function automatic int flit_w(input int port_tag_w, input int coord_w,
                                  input int pktid_w, input int data_w);
        return 1 + port_tag_w + 2 * coord_w + pktid_w + data_w;
    endfunction

    function automatic int off_data();
        return 0;
    endfunction

    function automatic int off_pktid(input int data_w);
        return data_w;
    endfunction

    function automatic int off_src(input int pktid_w, input int data_w);
        return data_w + pktid_w;
    endfunction

    function automatic int off_dst(input int coord_w, input int pktid_w,
                                   input int data_w);
        return data_w + pktid_w + coord_w;
    endfunction

    function automatic int off_port_tag(input int coord_w, input int pktid_w,
                                        input int data_w);
        return data_w + pktid_w + 2 * coord_w;
    endfunction

    function automatic int off_valid(input int port_tag_w, input int coord_w,
                                     input int pktid_w, input int data_w);
        return data_w + pktid_w + 2 * coord_w + port_tag_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inject_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inject_fifo                                                   |
// | Purpose  : DEPTH x WIDTH register FIFO with an occupancy count and a     |
// |            registered head output (all zero while empty).                |
// | Ports    : clk, rst      - clock, synchronous active-high reset          |
// |            i_push/i_wdata - write an entry (caller guarantees not full)  |
// |            i_pop         - retire head (caller guarantees not empty)     |
// |            o_head        - registered head entry, zero when empty        |
// |            o_full        - count == DEPTH                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inject_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  w_count_d;
    logic [WIDTH-1:0]   r_head_q,   w_head_d;

    assign o_full = (r_count_q == c_CNT_W'(DEPTH));
    assign o_head = r_head_q;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (i_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({i_push, i_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        // The head register looks one edge ahead. When the incoming entry
        // becomes the new head (queue empty, or last entry popped while a new
        // one arrives) it is not in storage yet, so take it from i_wdata.
        if (w_count_d == '0) begin
            w_head_d = '0;
        end else if (i_push && ((r_count_q == '0) ||
                                ((r_count_q == c_CNT_W'(1)) && i_pop))) begin
            w_head_d = i_wdata;
        end else begin
            w_head_d = r_mem_q[w_rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_head_q   <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_head_q   <= w_head_d;
        end
    end

    // Storage needs no reset: occupancy and head are cleared instead.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_q[r_wr_ptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/local_inject_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : local_inject_queue                                            |
// | Purpose  : Buffers PE flits for the router injection mux. Stamps source  |
// |            coordinate, wrapping packet ID and local port tag; holds the  |
// |            head until granted; flags starvation; counts grants.          |
// | Ports    : clk, reset        - clock, synchronous active-high reset      |
// |            cur_pos           - this router's {X,Y}                        |
// |            pe_valid/pe_ready - PE handshake; pe_dst, pe_data payload     |
// |            inj_req, inj_flit - registered head flit toward the router    |
// |            inj_grant         - router consumes the head this cycle       |
// |            starve            - head waited STARVE_LIMIT or more cycles    |
// |            inj_count         - saturating count of granted flits         |
// |            grant_err         - sticky, grant seen while empty            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module local_inject_queue
    import noc_flit_pkg::*;
#(
    parameter int                    DEPTH        = 4,
    parameter int                    DATA_W       = 32,
    parameter int                    COORD_W      = 4,
    parameter int                    PKTID_W      = 4,
    parameter int                    PORT_TAG_W   = 3,
    parameter logic [PORT_TAG_W-1:0] LOCAL_TAG    = PORT_TAG_W'(c_LOCAL_TAG),
    parameter int                    STARVE_LIMIT = 15,
    localparam int                   FLIT_W       = flit_w(PORT_TAG_W, COORD_W, PKTID_W, DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] cur_pos,
    input  logic               pe_valid,
    output logic               pe_ready,
    input  logic [COORD_W-1:0] pe_dst,
    input  logic [DATA_W-1:0]  pe_data,
    output logic               inj_req,
    output logic [FLIT_W-1:0]  inj_flit,
    input  logic               inj_grant,
    output logic               starve,
    output logic [15:0]        inj_count,
    output logic               grant_err
);

    localparam int c_WAIT_W    = $clog2(STARVE_LIMIT + 1);
    localparam int c_VALID_BIT = off_valid(PORT_TAG_W, COORD_W, PKTID_W, DATA_W);

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic [FLIT_W-1:0]   w_stamped;
    logic [FLIT_W-1:0]   w_head;
    logic [PKTID_W-1:0]  r_pkt_id_q,    w_pkt_id_d;
    logic [c_WAIT_W-1:0] r_wait_cnt_q,  w_wait_cnt_d;
    logic [15:0]         r_inj_count_q, w_inj_count_d;
    logic                r_grant_err_q, w_grant_err_d;

    // A stored entry always carries valid=1, so the head's valid bit is
    // exactly "queue not empty" and comes straight from a register.
    assign inj_req   = w_head[c_VALID_BIT];
    assign inj_flit  = w_head;
    assign pe_ready  = ~w_full & ~reset;
    assign starve    = (r_wait_cnt_q == c_WAIT_W'(STARVE_LIMIT));
    assign inj_count = r_inj_count_q;
    assign grant_err = r_grant_err_q;

    assign w_push    = pe_valid & pe_ready;
    assign w_pop     = inj_grant & inj_req;
    assign w_stamped = {1'b1, LOCAL_TAG, pe_dst, cur_pos, r_pkt_id_q, pe_data};

    inject_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_inject_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_stamped),
        .o_head  (w_head),
        .o_full  (w_full)
    );

    always_comb begin
        w_pkt_id_d    = r_pkt_id_q;
        w_wait_cnt_d  = r_wait_cnt_q;
        w_inj_count_d = r_inj_count_q;
        w_grant_err_d = r_grant_err_q | (inj_grant & ~inj_req);

        if (w_push) begin
            w_pkt_id_d = r_pkt_id_q + PKTID_W'(1);
        end

        // Count consecutive ungranted cycles of a present head flit.
        if (w_pop || !inj_req) begin
            w_wait_cnt_d = '0;
        end else if (r_wait_cnt_q != c_WAIT_W'(STARVE_LIMIT)) begin
            w_wait_cnt_d = r_wait_cnt_q + c_WAIT_W'(1);
        end

        if (w_pop && (r_inj_count_q != 16'hFFFF)) begin
            w_inj_count_d = r_inj_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_id_q    <= '0;
            r_wait_cnt_q  <= '0;
            r_inj_count_q <= '0;
            r_grant_err_q <= 1'b0;
        end else begin
            r_pkt_id_q    <= w_pkt_id_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
            r_inj_count_q <= w_inj_count_d;
            r_grant_err_q <= w_grant_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_local_inject_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_local_inject_queue                                         |
// | Purpose  : Self-checking bench for local_inject_queue. A behavioural     |
// |            model (occupancy, packet ID, wait and grant counters) pushes  |
// |            expected flits into a scoreboard; a monitor pops and compares |
// |            whenever the DUT retires a flit.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_local_inject_queue;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 15;

    logic        clk;
    logic        reset;
    logic [3:0]  cur_pos;
    logic        pe_valid;
    logic        pe_ready;
    logic [3:0]  pe_dst;
    logic [31:0] pe_data;
    logic        inj_req;
    logic [47:0] inj_flit;
    logic        inj_grant;
    logic        starve;
    logic [15:0] inj_count;
    logic        grant_err;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];

    // Model state describes the DUT as it stands before the coming edge.
    int m_cnt  = 0;
    int m_pid  = 0;
    int m_wait = 0;
    int m_icnt = 0;
    bit m_gerr = 1'b0;

    local_inject_queue dut (
        .clk       (clk),
        .reset     (reset),
        .cur_pos   (cur_pos),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .pe_dst    (pe_dst),
        .pe_data   (pe_data),
        .inj_req   (inj_req),
        .inj_flit  (inj_flit),
        .inj_grant (inj_grant),
        .starve    (starve),
        .inj_count (inj_count),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [47:0] mk_flit(input logic [3:0] dst, input int pid,
                                            input logic [31:0] data);
        return {1'b1, 3'd4, dst, cur_pos, 4'(pid), data};
    endfunction

    // Reference model: compare current outputs, then apply the coming edge.
    always @(negedge clk) begin
        bit push, pop;
        chk("pe_ready", 64'(pe_ready), 64'(!reset && (m_cnt < DEPTH)));
        chk("inj_req", 64'(inj_req), 64'(m_cnt > 0));
        if (m_cnt == 0) chk("empty_flit", 64'(inj_flit), 64'd0);
        chk("starve", 64'(starve), 64'(m_wait == STARVE_LIMIT));
        chk("inj_count", 64'(inj_count), 64'(m_icnt));
        chk("grant_err", 64'(grant_err), 64'(m_gerr));

        if (reset) begin
            m_cnt = 0; m_pid = 0; m_wait = 0; m_icnt = 0; m_gerr = 1'b0;
            exp_q.delete();
        end else begin
            push = pe_valid && (m_cnt < DEPTH);
            pop  = inj_grant && (m_cnt > 0);
            if (inj_grant && (m_cnt == 0)) m_gerr = 1'b1;
            if (pop && (m_icnt < 65535)) m_icnt++;
            if ((m_cnt == 0) || pop) m_wait = 0;
            else if (m_wait < STARVE_LIMIT) m_wait++;
            if (push) begin
                exp_q.push_back(mk_flit(pe_dst, m_pid, pe_data));
                m_pid = (m_pid + 1) % 16;
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    end

    // Monitor: every flit the DUT hands over must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && inj_req && inj_grant) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL flit_unexpected at %0t: got %h expected none", $time, inj_flit);
            end else begin
                chk("flit", 64'(inj_flit), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic v, input logic g, input logic [3:0] dst,
                        input logic [31:0] data);
        pe_valid  = v;
        inj_grant = g;
        pe_dst    = dst;
        pe_data   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 4'h0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int gprob;
        reset     = 1'b1;
        pe_valid  = 1'b0;
        inj_grant = 1'b0;
        pe_dst    = 4'h0;
        pe_data   = 32'h0;
        cur_pos   = 4'h2;
        @(posedge clk);
        #1;
        do_reset();

        // First flit stamped with pid 0, local tag and source coordinate.
        step(1'b1, 1'b0, 4'h5, 32'hA5A5A5A5);
        chk("first_flit", 64'(inj_flit), 64'h0000_C520_A5A5_A5A5);
        chk("first_req", 64'(inj_req), 64'd1);
        step(1'b0, 1'b1, 4'h0, 32'h0);

        // Fill, drop a fifth push, drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'($urandom), $urandom);
        chk("full_not_ready", 64'(pe_ready), 64'd0);
        step(1'b1, 1'b0, 4'hF, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0, 32'h0);
        chk("count_after_4", 64'(inj_count), 64'd4);

        // Push+grant while full, then at lower occupancies.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'($urandom), $urandom);
        step(1'b1, 1'b1, 4'($urandom), $urandom);
        chk("ready_after_full_pop", 64'(pe_ready), 64'd1);
        step(1'b1, 1'b1, 4'($urandom), $urandom);
        step(1'b0, 1'b1, 4'h0, 32'h0);
        step(1'b1, 1'b1, 4'($urandom), $urandom);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0, 32'h0);

        // Starvation boundary.
        step(1'b1, 1'b0, 4'h3, 32'h0BAD_F00D);
        repeat (14) step(1'b0, 1'b0, 4'h0, 32'h0);
        chk("starve_before_limit", 64'(starve), 64'd0);
        step(1'b0, 1'b0, 4'h0, 32'h0);
        chk("starve_at_limit", 64'(starve), 64'd1);
        step(1'b0, 1'b1, 4'h0, 32'h0);
        chk("starve_after_grant", 64'(starve), 64'd0);

        // 17 back-to-back flits: pkt_id wraps.
        step(1'b1, 1'b0, 4'($urandom), $urandom);
        repeat (16) step(1'b1, 1'b1, 4'($urandom), $urandom);
        step(1'b0, 1'b1, 4'h0, 32'h0);

        // Grant while empty.
        step(1'b0, 1'b1, 4'h0, 32'h0);
        chk("grant_err_set", 64'(grant_err), 64'd1);
        step(1'b1, 1'b0, 4'h7, 32'h7777_7777);
        step(1'b0, 1'b1, 4'h0, 32'h0);

        // Reset with three queued; push and grant in the reset cycle ignored.
        repeat (3) step(1'b1, 1'b0, 4'($urandom), $urandom);
        reset = 1'b1;
        step(1'b1, 1'b1, 4'h9, 32'h9999_9999);
        reset = 1'b0;
        chk("rst_inj_req", 64'(inj_req), 64'd0);
        chk("rst_inj_flit", 64'(inj_flit), 64'd0);
        chk("rst_inj_count", 64'(inj_count), 64'd0);
        step(1'b1, 1'b0, 4'h5, 32'h1234_5678);
        chk("pid_restart", 64'(inj_flit), 64'h0000_C520_1234_5678);
        step(1'b0, 1'b1, 4'h0, 32'h0);

        // Randomized traffic with varying grant pressure and rare resets.
        gprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) begin
                case ($urandom_range(0, 2))
                    0:       gprob = 5;
                    1:       gprob = 50;
                    default: gprob = 95;
                endcase
            end
            reset = ($urandom_range(0, 299) == 0);
            if (reset) cur_pos = 4'($urandom);
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < gprob,
                 4'($urandom), $urandom);
        end

        reset = 1'b0;
        repeat (8) step(1'b0, 1'b1, 4'h0, 32'h0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
